// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

    // Result sources, in round-robin order
    localparam int unsigned NSRC    = 3;
    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_VPU = 1;
    localparam int unsigned SRC_LSU = 2;

    // Addresses 24..31 name vector registers 0..7
    localparam logic [1:0] VREG_TAG = 2'b11;

    typedef struct packed {
        logic [4:0]   addr;
        logic [127:0] data;
    } wb_entry_t;

    function automatic logic is_vreg(input logic [4:0] addr);
        return addr[4:3] == VREG_TAG;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Result-source bus: per-source valid/ready handshake carrying {addr, data}.
interface regfile_writeback_if #(
    parameter int unsigned NSRC = 3
);
    logic [NSRC-1:0]        src_valid;
    logic [NSRC-1:0]        src_ready;
    logic [NSRC-1:0][4:0]   src_addr;
    logic [NSRC-1:0][127:0] src_data;

    modport master (output src_valid, output src_addr, output src_data, input src_ready);
    modport slave  (input src_valid, input src_addr, input src_data, output src_ready);
endinterface

// File: rtl/wb_fifo.sv
// Small per-source FIFO of write-back entries with synchronous reset.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back arbiter owning the register file write port, plus the
// pending-destination scoreboard used by decode for RAW stalls.
module regfile_writeback #(
    parameter int unsigned NSRC  = wb_pkg::NSRC,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  src,
    input  logic                claim_valid,
    input  logic [4:0]          claim_addr,
    output logic [31:0]         busy,
    output logic                we3,
    output logic [4:0]          a3,
    output logic [127:0]        wd3
);
    import wb_pkg::*;

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [NSRC-1:0]  full;
    logic [NSRC-1:0]  empty;
    wb_entry_t        head [NSRC];

    logic [IDX_W-1:0] last;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    wb_entry_t        gnt_entry;
    logic [31:0]      busy_nxt;

    assign src.src_ready = ~full;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        wb_entry_t din;

        assign din.addr = src.src_addr[g];
        assign din.data = src.src_data[g];
        assign push[g]  = src.src_valid[g] & ~full[g];
        assign pop[g]   = grant_valid && (grant_idx == IDX_W'(g));

        wb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .din   (din),
            .pop   (pop[g]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Round-robin search over non-empty FIFOs starting after the last grant
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            cand = IDX_W'((32'(last) + k) % NSRC);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign gnt_entry = head[grant_idx];

    // Registered write port; address-0 entries are drained without a write
    always_ff @(posedge clk) begin
        if (rst) begin
            we3  <= 1'b0;
            a3   <= '0;
            wd3  <= '0;
            last <= IDX_W'(NSRC - 1);
        end else if (grant_valid) begin
            last <= grant_idx;
            if (gnt_entry.addr != '0) begin
                we3 <= 1'b1;
                a3  <= gnt_entry.addr;
                wd3 <= is_vreg(gnt_entry.addr) ? gnt_entry.data
                                               : {96'b0, gnt_entry.data[31:0]};
            end else begin
                we3 <= 1'b0;
            end
        end else begin
            we3 <= 1'b0;
        end
    end

    // Scoreboard next state: clear on commit, then set on claim so set wins
    always_comb begin
        busy_nxt = busy;
        if (we3) begin
            busy_nxt[a3] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_nxt[claim_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, multi-cycle
// sequences, and a write-port scoreboard fed at stimulus time.
module tb_regfile_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         claim_valid;
    logic [4:0]   claim_addr;
    logic [31:0]  busy;
    logic         we3;
    logic [4:0]   a3;
    logic [127:0] wd3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]   a;
        logic [127:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int unsigned  src;
        logic [4:0]   addr;
        logic [127:0] data;
        logic [127:0] exp_wd;
    } vec_t;
    vec_t vecs[6];

    regfile_writeback_if #(.NSRC(3)) sif ();

    regfile_writeback #(
        .NSRC  (3),
        .DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src         (sif),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .busy        (busy),
        .we3         (we3),
        .a3          (a3),
        .wd3         (wd3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Scalar destinations keep only the low word; vector ones (24..31) keep all
    function automatic logic [127:0] model_wd(input logic [4:0] a, input logic [127:0] d);
        return (a >= 5'd24) ? d : {96'b0, d[31:0]};
    endfunction

    task automatic drive_src(input int unsigned s, input logic [4:0] a, input logic [127:0] d,
                             input bit expect_write);
        wr_t e;
        sif.src_valid[s] = 1'b1;
        sif.src_addr[s]  = a;
        sif.src_data[s]  = d;
        if (expect_write) begin
            e.a = a;
            e.d = model_wd(a, d);
            exp_q.push_back(e);
        end
    endtask

    // Write-port monitor: every write must match the next expected entry
    always @(negedge clk) begin
        wr_t e;
        if (we3 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got a3=%0d wd3=%0h required no write", a3, wd3);
            end else begin
                e = exp_q.pop_front();
                if (a3 !== e.a || wd3 !== e.d) begin
                    errors++;
                    $display("FAIL wr_content got a3=%0d wd3=%0h required a3=%0d wd3=%0h",
                             a3, wd3, e.a, e.d);
                end
            end
        end
    end

    initial begin
        logic [4:0]   aa [3][2];
        logic [127:0] ad [3][2];

        vecs[0] = '{0, 5'd5,  {96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'hDEADBEEF},
                    128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF};
        vecs[1] = '{1, 5'd26, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                    128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF};
        vecs[2] = '{2, 5'd17, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                    128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF};
        vecs[3] = '{1, 5'd23, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1234_5678,
                    128'h0000_0000_0000_0000_0000_0000_1234_5678};
        vecs[4] = '{0, 5'd24, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                    128'h8000_0000_0000_0000_0000_0000_0000_0001};
        vecs[5] = '{2, 5'd31, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC,
                    128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC};

        rst           = 1'b1;
        claim_valid   = 1'b0;
        claim_addr    = '0;
        sif.src_valid = '0;
        sif.src_addr  = '0;
        sif.src_data  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_we3", we3, 1'b0);
        chk("rst_a3", a3, 5'd0);
        chk("rst_wd3", wd3, 128'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", sif.src_ready, 3'b111);
        rst = 1'b0;

        // Single-entry vectors: latency, scalar/vector data shaping, a3 hold
        for (int i = 0; i < 6; i++) begin
            drive_src(vecs[i].src, vecs[i].addr, vecs[i].data, 1'b1);
            tick();
            sif.src_valid = '0;
            chk("vec_nobypass_we3", we3, 1'b0);
            chk("vec_ready_one_entry", sif.src_ready, 3'b111);
            tick();
            chk("vec_we3", we3, 1'b1);
            chk("vec_a3", a3, vecs[i].addr);
            chk("vec_wd3", wd3, vecs[i].exp_wd);
            tick();
            chk("vec_we3_drop", we3, 1'b0);
            chk("vec_a3_hold", a3, vecs[i].addr);
        end

        // Arbitration: every source pushes two entries on back-to-back edges
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 2; j++) begin
                aa[s][j] = (s == 1) ? 5'(24 + j) : 5'(8 + 4 * s + j);
                ad[s][j] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        for (int j = 0; j < 2; j++) begin
            for (int s = 0; s < 3; s++) begin
                drive_src(s, aa[s][j], ad[s][j], 1'b1);
            end
            tick();
            if (j == 0) begin
                chk("arb_first_no_write", we3, 1'b0);
                chk("arb_ready_after_first", sif.src_ready, 3'b111);
            end
        end
        sif.src_valid = '0;
        chk("arb_we3_0", we3, 1'b1);
        chk("arb_ready_full12", sif.src_ready, 3'b001);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk("arb_we3_run", we3, 1'b1);
            if (k == 1) chk("arb_ready_full2", sif.src_ready, 3'b011);
            if (k == 2) chk("arb_ready_none_full", sif.src_ready, 3'b111);
        end
        tick();
        chk("arb_we3_end", we3, 1'b0);

        // Scoreboard: claim, same-edge clear/set conflict, then clear
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        tick();
        claim_valid = 1'b0;
        chk("sb_claim7", busy, 32'h0000_0080);
        drive_src(0, 5'd7, 128'h1234, 1'b1);
        tick();
        sif.src_valid = '0;
        tick();
        chk("sb_we3_a3_7", {we3, a3}, {1'b1, 5'd7});
        chk("sb_busy_before_commit", busy, 32'h0000_0080);
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        tick();
        claim_valid = 1'b0;
        chk("sb_set_wins", busy, 32'h0000_0080);
        drive_src(0, 5'd7, 128'h5678, 1'b1);
        tick();
        sif.src_valid = '0;
        tick();
        chk("sb_busy_held_while_we3", busy, 32'h0000_0080);
        tick();
        chk("sb_cleared", busy, 32'd0);

        // Zero register: claim ignored, pushes drained with no write
        claim_valid = 1'b1;
        claim_addr  = 5'd0;
        tick();
        claim_valid = 1'b0;
        chk("zero_claim", busy, 32'd0);
        drive_src(0, 5'd0, 128'hBAD, 1'b0);
        tick();
        chk("zero_ready_one", sif.src_ready[0], 1'b1);
        tick();
        sif.src_valid = '0;
        chk("zero_no_we3", we3, 1'b0);
        tick();
        tick();
        chk("zero_no_we3_late", we3, 1'b0);
        chk("zero_ready_back", sif.src_ready, 3'b111);

        // Reset mid-stream with 4 entries buffered and busy = 0xF0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 4; r < 8; r++) begin
            claim_valid = 1'b1;
            claim_addr  = 5'(r);
            tick();
        end
        claim_valid = 1'b0;
        chk("mid_busy_f0", busy, 32'h0000_00F0);
        drive_src(0, 5'd10, 128'hA0, 1'b1);
        drive_src(1, 5'd11, 128'hA1, 1'b0);
        drive_src(2, 5'd12, 128'hA2, 1'b0);
        tick();
        sif.src_valid = '0;
        drive_src(0, 5'd13, 128'hB0, 1'b0);
        drive_src(1, 5'd14, 128'hB1, 1'b0);
        tick();
        chk("mid_we3_first", we3, 1'b1);
        sif.src_valid = 3'b100;
        sif.src_addr[2] = 5'd15;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sif.src_valid = '0;
        chk("mid_busy_cleared", busy, 32'd0);
        chk("mid_we3_cleared", we3, 1'b0);
        chk("mid_ready_all", sif.src_ready, 3'b111);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_no_write_after", we3, 1'b0);
        end

        chk("sb_queue_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
